// File: rtl/intr_pkg.sv
// intr_pkg: shared types, register offsets and helpers for the interrupt controller.
package intr_pkg;
    localparam int N_SRC = 8;
    localparam logic [1:0] OFF_MASK = 2'd0;
    localparam logic [1:0] OFF_PEND = 2'd1;
    localparam logic [1:0] OFF_INSV = 2'd2;
    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;
    function automatic logic [N_SRC-1:0] onehot(input logic [2:0] s);
        onehot = '0;
        onehot[s] = 1'b1;
    endfunction
    // Lowest set index wins; scanning downward lets the last hit be the lowest.
    function automatic logic [2:0] prio(input logic [N_SRC-1:0] v);
        prio = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (v[i]) prio = 3'(i);
    endfunction
endpackage

// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: CPU-side address/strobe and interrupt handshake signals.
interface intr_ctrl_if;
    import intr_pkg::*;
    logic [15:0]      Direcciones;
    logic             bus_we;
    logic             bus_re;
    logic             intr_ack;
    logic             iret;
    logic [N_SRC-1:0] intr;
    logic             busy;
    modport master (output Direcciones, bus_we, bus_re, intr_ack, iret, input intr, busy);
    modport slave  (input Direcciones, bus_we, bus_re, intr_ack, iret, output intr, busy);
endinterface

// File: rtl/sync_edge.sv
// sync_edge: 2-FF synchroniser followed by a rising-edge pulse on the synchronised line.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);
    logic [2:0] s;
    always_ff @(posedge clk or negedge reset)
        if (!reset) s <= '0;
        else        s <= {s[1:0], d};
    assign rise = s[1] & ~s[2];
endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-latched pending events, masked fixed-priority arbitration and
// a non-nesting REQ/SERV handshake toward the CPU, with a memory-mapped register file.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int          N_SRC     = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    inout  wire  [15:0]      Datos,
    intr_ctrl_if.slave       bus
);
    state_t           state, state_n;
    logic [2:0]       sel, sel_n;
    logic [N_SRC-1:0] rise, mask, pend, insv, insv_n, intr_q, intr_n, req, pend_clr, rdata;
    logic             busy_q, busy_n, hit, wr, rd, ack_take;
    logic [1:0]       off;
    wire              unused_ok = &{1'b0, Datos[15:8]};

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        sync_edge u_se (.clk(clk), .reset(reset), .d(irq_in[g]), .rise(rise[g]));
    end

    assign off      = bus.Direcciones[1:0];
    assign hit      = bus.Direcciones[15:2] == BASE_ADDR[15:2];
    assign wr       = bus.bus_we & hit;
    assign rd       = bus.bus_re & hit;
    assign req      = pend & mask;
    assign ack_take = state == REQ && bus.intr_ack && mask[sel] && pend[sel];
    assign pend_clr = (wr && off == OFF_PEND ? Datos[N_SRC-1:0] : '0) | (ack_take ? onehot(sel) : '0);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state  <= IDLE;
            sel    <= '0;
            mask   <= '0;
            pend   <= '0;
            insv   <= '0;
            intr_q <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            sel    <= sel_n;
            insv   <= insv_n;
            intr_q <= intr_n;
            busy_q <= busy_n;
            // A fresh edge overrides any clear on the same bit so the event survives.
            pend   <= (pend & ~pend_clr) | rise;
            if (wr && off == OFF_MASK) mask <= Datos[N_SRC-1:0];
        end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        insv_n  = insv;
        intr_n  = intr_q;
        busy_n  = busy_q;
        case (state)
            IDLE: if (|req) begin
                sel_n   = prio(req);
                intr_n  = onehot(sel_n);
                state_n = REQ;
            end
            REQ: if (!(mask[sel] && pend[sel])) begin
                intr_n  = '0;
                state_n = IDLE;
            end else if (bus.intr_ack) begin
                insv_n  = onehot(sel);
                intr_n  = '0;
                busy_n  = 1'b1;
                state_n = SERV;
            end
            SERV: if (bus.iret) begin
                insv_n  = '0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign rdata    = off == OFF_MASK ? mask : off == OFF_PEND ? pend : off == OFF_INSV ? insv : '0;
    assign Datos    = rd ? {{(16-N_SRC){1'b0}}, rdata} : 'z;
    assign bus.intr = intr_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed scoreboard bench for intr_ctrl; the bus is pulled up so a released Datos reads FFFF.
module tb_intr_ctrl;
    localparam logic [15:0] BASE = 16'hFF00;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  irq_in = '0;
    logic        drv = 1'b0;
    logic [15:0] dval = '0;
    wire  [15:0] Datos;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];

    intr_ctrl_if bus ();
    pullup (Datos);
    assign Datos = drv ? dval : 'z;

    intr_ctrl #(.N_SRC(8), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .Datos(Datos), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic wr(input logic [1:0] off, input logic [15:0] d);
        bus.Direcciones = BASE | {14'd0, off};
        bus.bus_we = 1'b1;
        drv = 1'b1;
        dval = d;
        tick();
        bus.bus_we = 1'b0;
        drv = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] e);
        push(e);
        bus.Direcciones = a;
        bus.bus_re = 1'b1;
        #1;
        check(tag, Datos);
        bus.bus_re = 1'b0;
        #1;
    endtask

    task automatic pulse_ack();
        bus.intr_ack = 1'b1;
        tick();
        bus.intr_ack = 1'b0;
    endtask

    task automatic pulse_iret();
        bus.iret = 1'b1;
        tick();
        bus.iret = 1'b0;
    endtask

    initial begin
        bus.Direcciones = '0;
        bus.bus_we = 1'b0;
        bus.bus_re = 1'b0;
        bus.intr_ack = 1'b0;
        bus.iret = 1'b0;
        // Reset and idle bus
        repeat (3) tick();
        push(16'h0000); check("rst_intr", {8'h00, bus.intr});
        push(16'h0000); check("rst_busy", {15'd0, bus.busy});
        reset = 1'b1;
        tick();
        rd("rd_mask0", BASE + 16'd0, 16'h0000);
        rd("rd_pend0", BASE + 16'd1, 16'h0000);
        rd("rd_insv0", BASE + 16'd2, 16'h0000);
        rd("rd_off3", BASE + 16'd3, 16'h0000);
        rd("rd_miss", 16'h1234, 16'hFFFF);
        push(16'hFFFF); check("bus_idle_z", Datos);
        // Basic request and return
        wr(2'd0, 16'h0008);
        rd("rd_mask8", BASE, 16'h0008);
        irq_in[3] = 1'b1;
        push(16'h0000);
        repeat (3) tick();
        check("lat_k2", {8'h00, bus.intr});
        push(16'h0008);
        tick();
        check("lat_k3", {8'h00, bus.intr});
        irq_in = '0;
        pulse_ack();
        push(16'h0000); check("ack_intr", {8'h00, bus.intr});
        push(16'h0001); check("ack_busy", {15'd0, bus.busy});
        rd("insv8", BASE + 16'd2, 16'h0008);
        rd("pend_clr", BASE + 16'd1, 16'h0000);
        pulse_iret();
        push(16'h0000); check("iret_busy", {15'd0, bus.busy});
        rd("insv_clr", BASE + 16'd2, 16'h0000);
        // Fixed priority
        wr(2'd0, 16'h00FF);
        irq_in = 8'h24;
        push(16'h0004);
        repeat (4) tick();
        check("prio_low", {8'h00, bus.intr});
        irq_in = '0;
        pulse_ack();
        pulse_iret();
        push(16'h0000); check("iret_c", {8'h00, bus.intr});
        push(16'h0020);
        tick();
        check("prio_next", {8'h00, bus.intr});
        pulse_ack();
        pulse_iret();
        // Masked line
        wr(2'd0, 16'h0000);
        irq_in[0] = 1'b1;
        push(16'h0000);
        repeat (4) tick();
        irq_in = '0;
        check("masked_noreq", {8'h00, bus.intr});
        rd("masked_pend", BASE + 16'd1, 16'h0001);
        wr(2'd0, 16'h0001);
        push(16'h0000); check("mask_wr_edge", {8'h00, bus.intr});
        push(16'h0001);
        tick();
        check("mask_wr_next", {8'h00, bus.intr});
        pulse_ack();
        pulse_iret();
        // Withdraw by MASK write
        wr(2'd0, 16'h0002);
        irq_in[1] = 1'b1;
        push(16'h0002);
        repeat (4) tick();
        irq_in = '0;
        check("req1", {8'h00, bus.intr});
        wr(2'd0, 16'h0000);
        push(16'h0000);
        tick();
        check("withdraw", {8'h00, bus.intr});
        pulse_ack();
        push(16'h0000); check("ack_idle", {15'd0, bus.busy});
        rd("withdraw_pend", BASE + 16'd1, 16'h0002);
        // Set wins over write-1-to-clear
        irq_in[1] = 1'b1;
        tick();
        tick();
        wr(2'd1, 16'h0002);
        irq_in = '0;
        rd("set_wins", BASE + 16'd1, 16'h0002);
        wr(2'd1, 16'h0002);
        rd("w1c", BASE + 16'd1, 16'h0000);
        // Reset mid-service
        wr(2'd0, 16'h0001);
        irq_in[0] = 1'b1;
        push(16'h0001);
        repeat (4) tick();
        irq_in = '0;
        check("req0", {8'h00, bus.intr});
        pulse_ack();
        push(16'h0001); check("serv_busy", {15'd0, bus.busy});
        reset = 1'b0;
        #1;
        push(16'h0000); check("async_busy", {15'd0, bus.busy});
        push(16'h0000); check("async_intr", {8'h00, bus.intr});
        #2;
        reset = 1'b1;
        tick();
        rd("post_mask", BASE + 16'd0, 16'h0000);
        rd("post_pend", BASE + 16'd1, 16'h0000);
        rd("post_insv", BASE + 16'd2, 16'h0000);
        push(16'h0000); check("post_intr", {8'h00, bus.intr});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
